// File: rtl/inv_subbytes_seq.sv
// inv_subbytes_seq: iterative AES InvSubBytes engine.
// Substitutes BYTES_PER_CYCLE bytes of a 128-bit state per clock with the
// FIPS-197 inverse S-box. Byte k lives at bits [8k+7:8k].
// Optional macro INV_SUBBYTES_REGOUT_EN adds a dedicated output register
// and a one-cycle HOLD state. That adds one cycle of latency and keeps
// state_out frozen while the next state is being worked on.
module inv_subbytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  generate
    if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
        BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bytes_per_cycle
      $error("inv_subbytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // With 16 bytes per cycle the step wraps to 0 in 4 bits, so cnt simply stays at 0.
  localparam logic [3:0] STEP     = 4'(BYTES_PER_CYCLE);
  localparam logic [3:0] LAST_CNT = 4'(16 - BYTES_PER_CYCLE);

  // Inverse S-box. Element 16*r+c is row r, column c of the FIPS-197 table.
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef INV_SUBBYTES_REGOUT_EN
    HOLD,
`endif
    DONE
  } state_t;

  state_t       state;
  state_t       next_state;
  logic [127:0] work;
  logic [127:0] work_sub;
  logic [3:0]   cnt;
  logic [3:0]   idx;
  logic         last_group;

  assign last_group = (cnt == LAST_CNT);

  // Substitute the current group of bytes, lowest index first; other bytes pass through.
  always_comb begin
    work_sub = work;
    idx      = cnt;
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      idx = cnt + 4'(i);
      work_sub[{idx, 3'b000} +: 8] = INV_SBOX[work[{idx, 3'b000} +: 8]];
    end
  end

  // FSM state register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; handshake outputs are decoded from state only.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          next_state = RUN;
        end
      end
      RUN: begin
        if (last_group) begin
`ifdef INV_SUBBYTES_REGOUT_EN
          next_state = HOLD;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef INV_SUBBYTES_REGOUT_EN
      HOLD: begin
        next_state = DONE;
      end
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Working register: load on accept, then rewrite one byte group per RUN cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= state_in;
            cnt  <= '0;
          end
        end
        RUN: begin
          work <= work_sub;
          cnt  <= cnt + STEP;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef INV_SUBBYTES_REGOUT_EN
  logic [127:0] out_reg;

  // Capture the finished state on the final RUN edge so state_out moves only there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= '0;
    end else if (state == RUN && last_group) begin
      out_reg <= work_sub;
    end
  end

  assign state_out = out_reg;
`else
  assign state_out = work;
`endif

endmodule
